// File: rtl/rev_level_fsm.sv
// rev_level_fsm -- engine revolution level tracker.
//
// Follows the requested level R one step at a time. A step only commits once the
// same step target has been seen for HOLD_CYCLES consecutive cycles. A request
// above MAX_LEVEL latches FAULT until the enable drops. All outputs are registered.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous, active-high; overrides everything
//   A           enable (1 = engine on)
//   R           requested level, sampled every cycle
//   C           current level (0 in OFF and FAULT)
//   qualifying  1 while a valid step request is being held (hold count nonzero)
//   step        one-cycle pulse in the first cycle C shows a new level
//   fault       1 while in FAULT
module rev_level_fsm #(
    parameter int LEVEL_W     = 2,
    parameter int MAX_LEVEL   = 3,
    parameter int HOLD_CYCLES = 4,
    parameter int ALLOW_DOWN  = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               A,
    input  logic [LEVEL_W-1:0] R,
    output logic [LEVEL_W-1:0] C,
    output logic               qualifying,
    output logic               step,
    output logic               fault
);

    localparam logic [1:0] ST_OFF   = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FAULT = 2'd2;

    // Level compares are done one bit wider so C+1 cannot wrap at the top code.
    localparam int              EW      = LEVEL_W + 1;
    localparam logic [EW-1:0]   E_ONE   = EW'(1);
    localparam logic [EW-1:0]   E_TWO   = EW'(2);
    localparam logic [EW-1:0]   E_MAX   = EW'(MAX_LEVEL);
    localparam int              Q_W     = $clog2(HOLD_CYCLES + 1);
    localparam logic [Q_W-1:0]  Q_ONE   = Q_W'(1);
    localparam logic [Q_W-1:0]  Q_HOLD  = Q_W'(HOLD_CYCLES);

    logic [1:0]         state_q, state_d;
    logic [LEVEL_W-1:0] c_q, c_d;
    logic [LEVEL_W-1:0] ht_q, ht_d;
    logic [Q_W-1:0]     q_q, q_d;
    logic               qual_q, qual_d;
    logic               step_q, step_d;
    logic               fault_q, fault_d;

    logic [EW-1:0]      r_ext, c_ext;
    logic               up_ok, down_ok, valid;
    logic [Q_W-1:0]     cnt_nxt;

    always_comb begin
        r_ext   = {1'b0, R};
        c_ext   = {1'b0, c_q};
        up_ok   = (r_ext == c_ext + E_ONE);
        // Stepping down to 0 is never a step; only dropping A reaches 0.
        down_ok = (ALLOW_DOWN != 0) && (c_ext >= E_TWO) && (r_ext == c_ext - E_ONE);
        valid   = (r_ext <= E_MAX) && (up_ok || down_ok);
        // A new target (including a direction reversal) restarts the count at 1.
        cnt_nxt = ((q_q == '0) || (R != ht_q)) ? Q_ONE : q_q + Q_ONE;

        state_d = state_q;
        c_d     = c_q;
        ht_d    = ht_q;
        q_d     = q_q;
        qual_d  = qual_q;
        step_d  = 1'b0;
        fault_d = fault_q;

        if (!A) begin
            state_d = ST_OFF;
            c_d     = '0;
            ht_d    = '0;
            q_d     = '0;
            qual_d  = 1'b0;
            step_d  = (c_q != '0);
            fault_d = 1'b0;
        end else if (state_q == ST_FAULT || r_ext > E_MAX) begin
            // FAULT is sticky while enabled, whatever R does.
            state_d = ST_FAULT;
            c_d     = '0;
            q_d     = '0;
            qual_d  = 1'b0;
            fault_d = 1'b1;
        end else if (valid) begin
            ht_d = R;
            if (cnt_nxt == Q_HOLD) begin
                state_d = ST_RUN;
                c_d     = R;
                step_d  = 1'b1;
                q_d     = '0;
                qual_d  = 1'b0;
            end else begin
                q_d    = cnt_nxt;
                qual_d = 1'b1;
            end
        end else begin
            // Level held or a multi-level skip: drop any pending qualification.
            q_d    = '0;
            qual_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_OFF;
            c_q     <= '0;
            ht_q    <= '0;
            q_q     <= '0;
            qual_q  <= 1'b0;
            step_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            ht_q    <= ht_d;
            q_q     <= q_d;
            qual_q  <= qual_d;
            step_q  <= step_d;
            fault_q <= fault_d;
        end
    end

    assign C          = c_q;
    assign qualifying = qual_q;
    assign step       = step_q;
    assign fault      = fault_q;

endmodule

// File: tb/tb_rev_level_fsm.sv
// Bench for rev_level_fsm. Four instances with different parameter sets; the one
// under test in a given cycle gets the vector, the others are held in reset.
// Each vector pushes its expected post-edge outputs into a scoreboard queue that
// a separate monitor drains one entry per clock.
module tb_rev_level_fsm;

    logic       clk = 1'b0;
    logic       rst  [4];
    logic       a    [4];
    logic [1:0] r    [4];
    logic [1:0] c    [4];
    logic       qual [4];
    logic       stp  [4];
    logic       flt  [4];

    always #5 clk = ~clk;

    // 0: defaults
    rev_level_fsm #(.LEVEL_W(2), .MAX_LEVEL(3), .HOLD_CYCLES(4), .ALLOW_DOWN(1)) u0 (
        .clk(clk), .reset(rst[0]), .A(a[0]), .R(r[0]),
        .C(c[0]), .qualifying(qual[0]), .step(stp[0]), .fault(flt[0]));
    // 1: no step-down
    rev_level_fsm #(.LEVEL_W(2), .MAX_LEVEL(3), .HOLD_CYCLES(4), .ALLOW_DOWN(0)) u1 (
        .clk(clk), .reset(rst[1]), .A(a[1]), .R(r[1]),
        .C(c[1]), .qualifying(qual[1]), .step(stp[1]), .fault(flt[1]));
    // 2: MAX_LEVEL below the top code so R = 3 is out of range
    rev_level_fsm #(.LEVEL_W(2), .MAX_LEVEL(2), .HOLD_CYCLES(4), .ALLOW_DOWN(1)) u2 (
        .clk(clk), .reset(rst[2]), .A(a[2]), .R(r[2]),
        .C(c[2]), .qualifying(qual[2]), .step(stp[2]), .fault(flt[2]));
    // 3: single-cycle response
    rev_level_fsm #(.LEVEL_W(2), .MAX_LEVEL(3), .HOLD_CYCLES(1), .ALLOW_DOWN(1)) u3 (
        .clk(clk), .reset(rst[3]), .A(a[3]), .R(r[3]),
        .C(c[3]), .qualifying(qual[3]), .step(stp[3]), .fault(flt[3]));

    typedef struct {
        int         d;
        string      nm;
        logic [1:0] c;
        logic       q;
        logic       s;
        logic       f;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    // Drive one vector n times; expected values are for right after the next edge.
    task automatic v(input int d, input string nm, input bit rs, input bit en,
                     input logic [1:0] ri, input logic [1:0] ec, input bit eq,
                     input bit es, input bit ef, input int n = 1);
        exp_t e;
        repeat (n) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                rst[k] = 1'b1; a[k] = 1'b0; r[k] = 2'd0;
            end
            rst[d] = rs; a[d] = en; r[d] = ri;
            e.d = d; e.nm = nm; e.c = ec; e.q = eq; e.s = es; e.f = ef;
            sb.push_back(e);
        end
    endtask

    // Monitor: one scoreboard entry per clock, sampled 1 ns after the edge.
    initial begin
        exp_t e;
        logic [4:0] got, want;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e    = sb.pop_front();
                got  = {c[e.d], qual[e.d], stp[e.d], flt[e.d]};
                want = {e.c, e.q, e.s, e.f};
                n_cmp++;
                if (got !== want) begin
                    n_fail++;
                    $display("FAIL %s dut%0d: got C=%0d qual=%b step=%b fault=%b, want C=%0d qual=%b step=%b fault=%b",
                             e.nm, e.d, got[4:3], got[2], got[1], got[0],
                             want[4:3], want[2], want[1], want[0]);
                end
            end
        end
    end

    initial begin
        for (int k = 0; k < 4; k++) begin
            rst[k] = 1'b1; a[k] = 1'b0; r[k] = 2'd0;
        end

        //        dut name        rst A  R  C  qual step flt  n
        // ---- defaults: first step and latency
        v(0, "reset",       1, 0, 0, 0, 0, 0, 0);
        v(0, "r1_hold",     0, 1, 1, 0, 1, 0, 0, 3);
        v(0, "r1_commit",   0, 1, 1, 1, 0, 1, 0);
        // ramp to 3
        v(0, "r2_hold",     0, 1, 2, 1, 1, 0, 0, 3);
        v(0, "r2_commit",   0, 1, 2, 2, 0, 1, 0);
        v(0, "r3_hold",     0, 1, 3, 2, 1, 0, 0, 3);
        v(0, "r3_commit",   0, 1, 3, 3, 0, 1, 0);
        v(0, "r3_steady",   0, 1, 3, 3, 0, 0, 0, 10);
        // step down
        v(0, "dn2_hold",    0, 1, 2, 3, 1, 0, 0, 3);
        v(0, "dn2_commit",  0, 1, 2, 2, 0, 1, 0);
        // back to 3, then drop A mid-qualification
        v(0, "up3_hold",    0, 1, 3, 2, 1, 0, 0, 3);
        v(0, "up3_commit",  0, 1, 3, 3, 0, 1, 0);
        v(0, "dn_partial",  0, 1, 2, 3, 1, 0, 0, 2);
        v(0, "a_off",       0, 0, 2, 0, 0, 1, 0);
        v(0, "off_idle",    0, 0, 0, 0, 0, 0, 0);
        // glitch restarts the count
        v(0, "g_r1_hold",   0, 1, 1, 0, 1, 0, 0, 3);
        v(0, "g_r1_commit", 0, 1, 1, 1, 0, 1, 0);
        v(0, "g_r2_a",      0, 1, 2, 1, 1, 0, 0, 3);
        v(0, "g_glitch",    0, 1, 1, 1, 0, 0, 0);
        v(0, "g_r2_b",      0, 1, 2, 1, 1, 0, 0, 3);
        v(0, "g_r2_commit", 0, 1, 2, 2, 0, 1, 0);
        // direction reversal restarts at 1
        v(0, "rev_up",      0, 1, 3, 2, 1, 0, 0, 2);
        v(0, "rev_dn",      0, 1, 1, 2, 1, 0, 0, 3);
        v(0, "rev_commit",  0, 1, 1, 1, 0, 1, 0);
        // two-level skip never qualifies
        v(0, "skip",        0, 1, 3, 1, 0, 0, 0, 20);
        // reset mid-qualification
        v(0, "rq_hold",     0, 1, 2, 1, 1, 0, 0, 2);
        v(0, "rq_reset",    1, 1, 2, 0, 0, 0, 0);
        v(0, "off_r2",      0, 1, 2, 0, 0, 0, 0);

        // ---- ALLOW_DOWN = 0
        v(1, "nd_reset",    1, 0, 0, 0, 0, 0, 0);
        v(1, "nd_r1_hold",  0, 1, 1, 0, 1, 0, 0, 3);
        v(1, "nd_r1",       0, 1, 1, 1, 0, 1, 0);
        v(1, "nd_r2_hold",  0, 1, 2, 1, 1, 0, 0, 3);
        v(1, "nd_r2",       0, 1, 2, 2, 0, 1, 0);
        v(1, "nd_r3_hold",  0, 1, 3, 2, 1, 0, 0, 3);
        v(1, "nd_r3",       0, 1, 3, 3, 0, 1, 0);
        v(1, "nd_down",     0, 1, 2, 3, 0, 0, 0, 4);
        v(1, "nd_a_off",    0, 0, 2, 0, 0, 1, 0);

        // ---- MAX_LEVEL = 2: fault handling
        v(2, "f_reset",     1, 0, 0, 0, 0, 0, 0);
        v(2, "f_r1_hold",   0, 1, 1, 0, 1, 0, 0, 3);
        v(2, "f_r1",        0, 1, 1, 1, 0, 1, 0);
        v(2, "f_r2_hold",   0, 1, 2, 1, 1, 0, 0, 3);
        v(2, "f_r2",        0, 1, 2, 2, 0, 1, 0);
        v(2, "f_enter",     0, 1, 3, 0, 0, 0, 1);
        v(2, "f_sticky",    0, 1, 1, 0, 0, 0, 1, 4);
        v(2, "f_sticky3",   0, 1, 3, 0, 0, 0, 1);
        v(2, "f_leave",     0, 0, 1, 0, 0, 0, 0);
        v(2, "f_re_hold",   0, 1, 1, 0, 1, 0, 0, 3);
        v(2, "f_re_commit", 0, 1, 1, 1, 0, 1, 0);
        v(2, "f_from_off3", 0, 0, 0, 0, 0, 1, 0);
        v(2, "f_off_enter", 0, 1, 3, 0, 0, 0, 1);

        // ---- HOLD_CYCLES = 1
        v(3, "h1_reset",    1, 0, 0, 0, 0, 0, 0);
        v(3, "h1_up1",      0, 1, 1, 1, 0, 1, 0);
        v(3, "h1_stay",     0, 1, 1, 1, 0, 0, 0);
        v(3, "h1_up2",      0, 1, 2, 2, 0, 1, 0);
        v(3, "h1_up3",      0, 1, 3, 3, 0, 1, 0);
        v(3, "h1_dn2",      0, 1, 2, 2, 0, 1, 0);
        v(3, "h1_dn1",      0, 1, 1, 1, 0, 1, 0);
        v(3, "h1_no_dn0",   0, 1, 0, 1, 0, 0, 0);

        // Drain the scoreboard, bounded.
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
